// File: rtl/im2col_scheduler.sv
// 3x3 / stride-1 / no-padding im2col window scheduler: fetches each window from image memory and presents it as one patch.
// Optional backpressure counter enabled by defining IM2COL_SCHED_STALL_CNT_EN.
module im2col_scheduler #(
    parameter  int IMG_W = 28,
    parameter  int IMG_H = 28,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(IMG_W * IMG_H),
    localparam int RW    = $clog2(IMG_H - 2),
    localparam int CW    = $clog2(IMG_W - 2)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic            patch_valid,
    input  logic            patch_ready,
    output logic [9*DW-1:0] patch_data,
    output logic [RW-1:0]   patch_row,
    output logic [CW-1:0]   patch_col,
    output logic            patch_last,
    output logic [31:0]     stall_cycles
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, EMIT} state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 3);

    state_t            state_q;
    logic              busy_q, done_q, rd_en_q, valid_q, last_q;
    logic [AW-1:0]     rd_addr_q;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [1:0]        m_q, n_q, m_d, n_d;
    logic              last_win_d;
    logic              cap_vld_q;
    logic [3:0]        cap_slot_q;
    logic [9*DW-1:0]   patch_data_q;

    function automatic logic [AW-1:0] pix_addr(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                               input logic [1:0] m, input logic [1:0] n);
        logic [AW-1:0] rr, cc;
        rr = AW'(r) + AW'(m);
        cc = AW'(c) + AW'(n);
        return rr * AW'(IMG_W) + cc;
    endfunction

    // Next window origin (raster order) and next in-window read position
    always_comb begin
        last_win_d = (row_q == LAST_ROW) && (col_q == LAST_COL);
        row_d      = row_q;
        col_d      = col_q + 1'b1;
        if (col_q == LAST_COL) begin
            row_d = row_q + 1'b1;
            col_d = '0;
        end
        m_d = m_q;
        n_d = n_q + 2'd1;
        if (n_q == 2'd2) begin
            m_d = m_q + 2'd1;
            n_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            m_q       <= '0;
            n_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                // Abort beats any handshake in the same cycle; the patch is dropped
                state_q <= IDLE;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q   <= FETCH;
                            busy_q    <= 1'b1;
                            row_q     <= '0;
                            col_q     <= '0;
                            m_q       <= '0;
                            n_q       <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                        end
                    end
                    FETCH: begin
                        if ((m_q == 2'd2) && (n_q == 2'd2)) begin
                            rd_en_q <= 1'b0;
                            state_q <= CAPTURE;
                        end else begin
                            m_q       <= m_d;
                            n_q       <= n_d;
                            rd_addr_q <= pix_addr(row_q, col_q, m_d, n_d);
                        end
                    end
                    CAPTURE: begin
                        state_q <= EMIT;
                        valid_q <= 1'b1;
                        last_q  <= last_win_d;
                    end
                    EMIT: begin
                        if (patch_ready) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (last_win_d) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= FETCH;
                                row_q     <= row_d;
                                col_q     <= col_d;
                                m_q       <= '0;
                                n_q       <= '0;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= pix_addr(row_d, col_d, 2'd0, 2'd0);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Memory answers one cycle after the strobe, so the slot index trails the read by a cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_vld_q    <= 1'b0;
            cap_slot_q   <= '0;
            patch_data_q <= '0;
        end else begin
            cap_vld_q  <= rd_en_q && !abort;
            cap_slot_q <= {2'b00, m_q} * 4'd3 + {2'b00, n_q};
            if (cap_vld_q) begin
                patch_data_q[cap_slot_q*DW +: DW] <= rd_data;
            end
        end
    end

`ifdef IM2COL_SCHED_STALL_CNT_EN
    logic [31:0] stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (start && (state_q == IDLE)) begin
            stall_q <= '0;
        end else if (valid_q && !patch_ready) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign patch_valid = valid_q;
    assign patch_data  = patch_data_q;
    assign patch_row   = row_q;
    assign patch_col   = col_q;
    assign patch_last  = last_q;

endmodule

// File: tb/tb_im2col_scheduler.sv
// Scoreboard bench for im2col_scheduler on a 28x28 image with pixel(r,c) = (r*28+c) % 256.
module tb_im2col_scheduler;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int DW    = 8;
    localparam int NR    = IMG_H - 2;
    localparam int NC    = IMG_W - 2;
`ifdef IM2COL_SCHED_STALL_CNT_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, abort, patch_ready;
    logic        busy, done, rd_en, patch_valid, patch_last;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data = '0;
    logic [71:0] patch_data;
    logic [4:0]  patch_row, patch_col;
    logic [31:0] stall_cycles;

    typedef struct packed {
        logic [4:0]  r;
        logic [4:0]  c;
        logic [71:0] d;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0, done_cnt = 0;
    int   stall_req = 0, stall_r = 0, stall_c = 0;
    logic base_ready = 1'b1;

    im2col_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .patch_valid(patch_valid),
        .patch_ready(patch_ready), .patch_data(patch_data), .patch_row(patch_row),
        .patch_col(patch_col), .patch_last(patch_last), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Image memory: address r*28+c holds (r*28+c) % 256
    always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0];

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_patch(input int r, input int c);
        logic [71:0] d;
        d = '0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                d[(m*3+n)*8 +: 8] = 8'(((r + m) * IMG_W + c + n) % 256);
        return d;
    endfunction

    task automatic push_run();
        exp_t e;
        sb_q.delete();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                e.r    = 5'(r);
                e.c    = 5'(c);
                e.d    = exp_patch(r, c);
                e.last = (r == NR - 1) && (c == NC - 1);
                sb_q.push_back(e);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_req > 0 && patch_valid && int'(patch_row) == stall_r && int'(patch_col) == stall_c) begin
            patch_ready = 1'b0;
            stall_req--;
            if (sb_q.size() > 0) check_val("stall_data", patch_data, sb_q[0].d);
            else check_val("stall_sb_empty", 0, 1);
        end else begin
            patch_ready = base_ready;
        end
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        repeat (3) tick();
        check_val("done_pulses", done_cnt - d0, 1);
    endtask

    // Output monitor: every accepted patch is compared against the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                check_val("busy_at_done", busy, 0);
            end
            if (patch_valid && patch_ready && !abort) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_patch", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("patch_row", patch_row, mon_e.r);
                    check_val("patch_col", patch_col, mon_e.c);
                    check_val("patch_data", patch_data, mon_e.d);
                    check_val("patch_last", patch_last, mon_e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int d0;
        bit found;
        reset = 1'b1; start = 1'b0; abort = 1'b0; patch_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rd_en", rd_en, 0);
        check_val("rst_rd_addr", rd_addr, 0);
        check_val("rst_valid", patch_valid, 0);
        check_val("rst_data", patch_data, 0);
        check_val("rst_row", patch_row, 0);
        check_val("rst_col", patch_col, 0);
        check_val("rst_last", patch_last, 0);
        check_val("rst_stall", stall_cycles, 0);
        reset = 1'b0;
        tick();

        // Full run, ready always high, with latency/address checks and spurious starts
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("lat_rd_en", rd_en, 1);
        check_val("lat_busy", busy, 1);
        check_val("addr_0", rd_addr, 0);
        for (int k = 1; k < 9; k++) begin
            tick();
            check_val("fetch_rd_en", rd_en, 1);
            check_val("fetch_addr", rd_addr, (k / 3) * IMG_W + (k % 3));
        end
        tick();
        check_val("capture_rd_en", rd_en, 0);
        check_val("capture_valid", patch_valid, 0);
        check_val("capture_addr_hold", rd_addr, 2 * IMG_W + 2);
        tick();
        check_val("lat_valid", patch_valid, 1);
        repeat (30) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (400) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(8000);
        check_val("run1_sb_empty", sb_q.size(), 0);
        check_val("run1_stall", stall_cycles, 0);
        check_val("run1_busy", busy, 0);

        // Backpressure on patch (3,7) for 5 cycles
        push_run();
        stall_req = 5; stall_r = 3; stall_c = 7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(8000);
        check_val("stall_applied", stall_req, 0);
        check_val("stall_count", stall_cycles, STALL_EXP);
        check_val("run2_sb_empty", sb_q.size(), 0);

        // Abort during fetch of window (10,4)
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            tick();
            if (busy && rd_en && patch_row == 5'd10 && patch_col == 5'd4) found = 1;
        end
        check_val("abort_win_found", found, 1);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_rd_en", rd_en, 0);
        check_val("abort_valid", patch_valid, 0);
        check_val("abort_sb_left", sb_q.size(), NR * NC - (10 * NC + 4));
        repeat (5) tick();
        check_val("abort_no_done", done_cnt - d0, 0);

        // Restart with start+abort together, then abort on the last handshake
        push_run();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_val("restart_busy", busy, 1);
        for (int i = 0; i < 50 && sb_q.size() == NR * NC; i++) tick();
        check_val("restart_first", sb_q.size(), NR * NC - 1);
        found = 0;
        for (int i = 0; i < 8000 && !found; i++) begin
            tick();
            if (patch_valid && patch_last) found = 1;
        end
        check_val("last_found", found, 1);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("lastabort_busy", busy, 0);
        check_val("lastabort_valid", patch_valid, 0);
        check_val("lastabort_sb_left", sb_q.size(), 1);
        repeat (3) tick();
        check_val("lastabort_no_done", done_cnt - d0, 0);
        sb_q.delete();

        // Asynchronous reset while holding a patch in EMIT
        base_ready = 1'b0;
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !patch_valid; i++) tick();
        check_val("rst_emit_reached", patch_valid, 1);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_rd_en", rd_en, 0);
        check_val("arst_valid", patch_valid, 0);
        check_val("arst_data", patch_data, 0);
        check_val("arst_rd_addr", rd_addr, 0);
        check_val("arst_last", patch_last, 0);
        check_val("arst_stall", stall_cycles, 0);
        tick();
        push_run();
        base_ready = 1'b1;
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("post_rst_busy", busy, 1);
        for (int i = 0; i < 20 && sb_q.size() == NR * NC; i++) tick();
        check_val("post_rst_first", sb_q.size(), NR * NC - 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb_q.delete();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/im2col_scheduler.md
IM2COL_SCHEDULER -- requirements
Module: im2col_scheduler

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels.
REQ-002 Parameter IMG_H, default 28, image height in pixels.
REQ-003 Parameter DW, default 8, pixel width in bits; kernel fixed at 3x3, stride 1, no padding.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a conversion of the full image.
REQ-007 abort  in  1  terminates a conversion in progress.
REQ-008 busy  out  1  high from the start-accept cycle until return to IDLE.
REQ-009 done  out  1  one-cycle pulse after the last patch handshake.
REQ-010 rd_en  out  1  image memory read strobe.
REQ-011 rd_addr  out  clog2(IMG_W*IMG_H)  pixel address = row*IMG_W + col.
REQ-012 rd_data  in  DW  pixel returned exactly one cycle after rd_en.
REQ-013 patch_valid  out  1  patch_data holds a complete 3x3 window.
REQ-014 patch_ready  in  1  downstream accepts the patch.
REQ-015 patch_data  out  9*DW  element m*3+n (window row m, column n) at bits [(m*3+n)*DW +: DW].
REQ-016 patch_row, patch_col  out  clog2(IMG_H-2), clog2(IMG_W-2)  window origin.
REQ-017 patch_last  out  1  high with patch_valid for window (IMG_H-3, IMG_W-3).
REQ-018 stall_cycles  out  32  backpressure counter (see Configuration).

Function
REQ-019 States: IDLE, FETCH, CAPTURE, EMIT.
REQ-020 IDLE: start=1 -> FETCH, window (0,0), busy=1; start ignored in every other state.
REQ-021 FETCH: 9 consecutive cycles, rd_en=1, addresses in order m=0..2, n=0..2: (row+m)*IMG_W + (col+n).
REQ-022 Each rd_data is written into patch_data slot m*3+n the cycle after its read; CAPTURE (1 cycle, rd_en=0) receives the 9th pixel.
REQ-023 EMIT: patch_valid=1; patch_data, patch_row, patch_col and patch_last remain stable until patch_valid && patch_ready.
REQ-024 Handshake in EMIT, not last window: col+1; at col=IMG_W-3, col=0 and row+1; -> FETCH the following cycle.
REQ-025 Handshake on the last window: -> IDLE, done=1 for one cycle, busy=0 in that same cycle.
REQ-026 Latency: the first rd_en is 1 cycle after the start edge; patch_valid rises 11 cycles after that edge; minimum 11 cycles per window; (IMG_H-2)*(IMG_W-2) patches per run.
REQ-027 patch_valid never depends combinationally on patch_ready; patch_ready while not in EMIT is ignored.
REQ-028 abort=1 in any non-IDLE state -> IDLE on the next edge; no done; the in-flight patch is discarded; abort wins over a simultaneous handshake.
REQ-029 start and abort both high in IDLE: start is accepted and abort is ignored.
REQ-030 Outside FETCH, rd_en=0 and rd_addr holds its last value.

Reset
REQ-031 reset asserted sets: state IDLE, busy=0, done=0, rd_en=0, rd_addr=0, patch_valid=0, patch_data=0, patch_row=0, patch_col=0, patch_last=0, stall_cycles=0.
REQ-032 reset mid-conversion aborts immediately; no done; start is accepted in the first cycle after reset deasserts.

Configuration
REQ-033 With macro IM2COL_SCHED_STALL_CNT_EN defined, stall_cycles increments (saturating at 2^32-1) every cycle patch_valid && !patch_ready, and clears on an accepted start.
REQ-034 With IM2COL_SCHED_STALL_CNT_EN undefined, stall_cycles is constant 0 and the counter logic is absent; all other behaviour is identical.

Verification
REQ-035 Image pixel(r,c)=(r*28+c)%256, patch_ready=1 -> 676 patches; patch(0,0) = {0,1,2,28,29,30,56,57,58}; last patch at (25,25) with patch_last=1; one done pulse.
REQ-036 Same image, patch_ready held 0 for 5 cycles on patch (3,7) -> patch_data stable throughout; stall_cycles=5 (macro on) or 0 (macro off).
REQ-037 abort during FETCH of window (10,4) -> IDLE next cycle, no done, busy=0; a new start restarts at (0,0).
REQ-038 reset asserted during EMIT -> all outputs at reset values asynchronously; start after release yields correct patch (0,0).
REQ-039 start pulsed while busy, and patch_ready high outside EMIT -> no effect; the patch sequence is unchanged.
REQ-040 abort coincident with the handshake of the last window -> no done; state IDLE.
